// File: rtl/mem_access_pkg.sv
// Shared types and funct3 encodings for the memory-stage access controller.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } mem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Combinational load formatter: selects the byte/halfword lane and extends it.
module load_formatter
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    always_comb begin
        case (offset)
            2'd0:    b_sel = rdata[7:0];
            2'd1:    b_sel = rdata[15:8];
            2'd2:    b_sel = rdata[23:16];
            default: b_sel = rdata[31:24];
        endcase
        h_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   data = {{24{b_sel[7]}}, b_sel};
            F3_LH:   data = {{16{h_sel[15]}}, h_sel};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'd0, b_sel};
            F3_LHU:  data = {16'd0, h_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller driving a valid/grant data-memory port.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              invalid_in,
    input  logic              memtoreg_in,
    input  logic [3:0]        memwrite_in,
    input  logic [ADDR_W-1:0] ALUout_in,
    input  logic [DATA_W-1:0] rdata2_in,
    input  logic [31:0]       inst_data_in,
    output logic              stall_out,
    output logic [DATA_W-1:0] load_data_out,
    output logic              load_valid_out,
    output logic              dmem_req_out,
    output logic [3:0]        dmem_we_out,
    output logic [ADDR_W-1:0] dmem_addr_out,
    output logic [DATA_W-1:0] dmem_wdata_out,
    input  logic              dmem_gnt_in,
    input  logic              dmem_rvalid_in,
    input  logic [DATA_W-1:0] dmem_rdata_in
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misaligned_out
`endif
);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              load_q, load_d;
    logic [DATA_W-1:0] ldata_q, ldata_d;
    logic              mis_q, mis_d;

    logic [2:0]        f3_in;
    logic              is_store;
    logic              pending;
    logic              trap;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] fmt_data;
    logic              unused_inst;

    assign f3_in       = inst_data_in[14:12];
    assign unused_inst = ^{inst_data_in[31:15], inst_data_in[11:0]};
    assign is_store    = |memwrite_in;
    assign pending     = !invalid_in && (memtoreg_in || is_store);

    always_comb begin
        case (f3_in)
            F3_SB:   store_data = {4{rdata2_in[7:0]}};
            F3_SH:   store_data = {2{rdata2_in[15:0]}};
            default: store_data = rdata2_in;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        if (is_store) begin
            trap = ((f3_in == F3_SH) && ALUout_in[0]) ||
                   ((f3_in == F3_SW) && (ALUout_in[1:0] != 2'b00));
        end else begin
            trap = (((f3_in == F3_LH) || (f3_in == F3_LHU)) && ALUout_in[0]) ||
                   ((f3_in == F3_LW) && (ALUout_in[1:0] != 2'b00));
        end
    end
    assign misaligned_out = (state_q == DONE) && mis_q;
`else
    assign trap = 1'b0;
`endif

    load_formatter u_fmt (
        .rdata  (dmem_rdata_in),
        .funct3 (f3_q),
        .offset (off_q),
        .data   (fmt_data)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        f3_d           = f3_q;
        off_d          = off_q;
        load_d         = load_q;
        ldata_d        = ldata_q;
        mis_d          = mis_q;
        stall_out      = 1'b0;
        dmem_req_out   = 1'b0;
        load_valid_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending) begin
                    stall_out = 1'b1;
                    addr_d    = {ALUout_in[ADDR_W-1:2], 2'b00};
                    we_d      = memwrite_in;
                    wdata_d   = store_data;
                    f3_d      = f3_in;
                    off_d     = ALUout_in[1:0];
                    load_d    = !is_store;
                    mis_d     = trap;
                    state_d   = trap ? DONE : REQ;
                end
            end
            REQ: begin
                stall_out    = 1'b1;
                dmem_req_out = 1'b1;
                if (dmem_gnt_in) begin
                    state_d = load_q ? WAIT : DONE;
                end
            end
            WAIT: begin
                stall_out = 1'b1;
                if (dmem_rvalid_in) begin
                    ldata_d = fmt_data;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Pipeline advances this cycle; IDLE then sees the next EX/MEM contents.
                load_valid_out = load_q && !mis_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            load_q  <= 1'b0;
            ldata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            load_q  <= load_d;
            ldata_q <= ldata_d;
            mis_q   <= mis_d;
        end
    end

    assign load_data_out  = ldata_q;
    assign dmem_we_out    = we_q;
    assign dmem_addr_out  = addr_q;
    assign dmem_wdata_out = wdata_q;

endmodule
